// File: rtl/ex_mem_flag_stage.sv
// EX/MEM stage: registers ALU result, owns the {N,Z,V} flag register, resolves branches.
// Define FLAG_BYPASS_EN to forward in-flight EX flags to the branch instead of raising a hazard.
module ex_mem_flag_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_is_alu,
  input  logic [2:0]        ex_op,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [2:0]        ex_flag,
  input  logic              ex_wr_reg,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              br_valid,
  input  logic [2:0]        br_ccc,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_out,
  output logic              mem_wr_reg,
  output logic [REG_AW-1:0] mem_rd,
  output logic [2:0]        flag_q,
  output logic              br_taken,
  output logic              br_hazard
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              wr_q, wr_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [2:0]        flag_d;
  logic [2:0]        flag_en;
  logic              pending;
  logic [2:0]        f;
  logic              cond;

  // Per-bit flag write enables {N,Z,V} by opcode
  always_comb begin
    flag_en = 3'b000;
    case (ex_op)
      3'd0, 3'd1:             flag_en = 3'b111;
      3'd3, 3'd4, 3'd5, 3'd6: flag_en = 3'b010;
      default:                flag_en = 3'b000;
    endcase
  end

  assign pending = ex_valid & ex_is_alu & ~flush & (|flag_en);

`ifdef FLAG_BYPASS_EN
  logic [2:0] fwd_en;
  assign fwd_en    = pending ? flag_en : 3'b000;
  assign f         = (flag_q & ~fwd_en) | (ex_flag & fwd_en);
  assign br_hazard = 1'b0;
`else
  assign f         = flag_q;
  assign br_hazard = br_valid & pending & (br_ccc != 3'b111);
`endif

  always_comb begin
    cond = 1'b0;
    case (br_ccc)
      3'b000:  cond = ~f[1];
      3'b001:  cond = f[1];
      3'b010:  cond = ~f[1] & ~f[2];
      3'b011:  cond = f[2];
      3'b100:  cond = f[1] | ~f[2];
      3'b101:  cond = f[2] | f[1];
      3'b110:  cond = f[0];
      default: cond = 1'b1;
    endcase
  end

  assign br_taken = br_valid & cond & ~br_hazard;

  always_comb begin
    valid_d = valid_q;
    alu_d   = alu_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    flag_d  = flag_q;
    if (flush) begin
      valid_d = 1'b0;
      wr_d    = 1'b0;
    end else if (!stall) begin
      valid_d = ex_valid;
      alu_d   = ex_alu_out;
      wr_d    = ex_valid & ex_wr_reg;
      rd_d    = ex_rd;
      if (ex_valid & ex_is_alu)
        flag_d = (flag_q & ~flag_en) | (ex_flag & flag_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      flag_q  <= 3'b000;
    end else begin
      valid_q <= valid_d;
      alu_q   <= alu_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      flag_q  <= flag_d;
    end
  end

  assign mem_valid   = valid_q;
  assign mem_alu_out = alu_q;
  assign mem_wr_reg  = wr_q;
  assign mem_rd      = rd_q;

endmodule
